// File: rtl/rv32i_types.sv
// Shared RV32I core types.
// Data-memory line responder state and address-split constants.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    RESP
  } dmem_state_t;

  localparam int LINE_OFFSET_BITS = 5;
  localparam int BEAT_SEL_LSB     = 3;

endpackage

// File: rtl/dmem_line_responder_store.sv
// Single-line data store: 256-bit line plus tag/valid/dirty.
// Beat-wide fill/read for bursts, word-wide masked write/read for the CPU.
module dmem_line_store
  import rv32i_types::*;
#(
  parameter int width      = 32,
  parameter int PMEM_WIDTH = 64,
  parameter int BEATS      = 4,
  localparam int CW        = $clog2(BEATS),
  localparam int TAG_W     = width - LINE_OFFSET_BITS,
  localparam int LANES     = width / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill_we,
  input  logic [CW-1:0]         fill_idx,
  input  logic [PMEM_WIDTH-1:0] fill_data,
  input  logic                  word_we,
  input  logic [CW-1:0]         word_idx,
  input  logic                  word_half,
  input  logic [width-1:0]      word_wdata,
  input  logic [LANES-1:0]      word_be,
  input  logic                  set_valid,
  input  logic [TAG_W-1:0]      new_tag,
  input  logic                  clr_dirty,
  input  logic                  set_dirty,
  input  logic [CW-1:0]         beat_idx,
  output logic [PMEM_WIDTH-1:0] beat_rdata,
  output logic [width-1:0]      word_rdata,
  output logic                  valid,
  output logic                  dirty,
  output logic [TAG_W-1:0]      tag
);

  logic [PMEM_WIDTH-1:0] line_q [BEATS];
  logic [PMEM_WIDTH-1:0] word_beat;

  // Line contents survive reset; only the metadata is cleared.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      line_q[fill_idx] <= fill_data;
    end else if (word_we) begin
      for (int k = 0; k < LANES; k++) begin
        if (word_be[k]) begin
          if (word_half)
            line_q[word_idx][width + 8*k +: 8] <= word_wdata[8*k +: 8];
          else
            line_q[word_idx][8*k +: 8] <= word_wdata[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      dirty <= 1'b0;
      tag   <= '0;
    end else begin
      if (set_valid) begin
        valid <= 1'b1;
        tag   <= new_tag;
      end
      if (clr_dirty)
        dirty <= 1'b0;
      else if (set_dirty)
        dirty <= 1'b1;
    end
  end

  assign beat_rdata = line_q[beat_idx];
  assign word_beat  = line_q[word_idx];
  assign word_rdata = word_half ? word_beat[2*width-1:width]
                                : word_beat[width-1:0];

endmodule

// File: rtl/dmem_line_responder.sv
// Data-memory responder for the MEM stage: one-line buffer with
// dirty write-back and 4-beat burst refill toward the pmem arbiter.
module dmem_line_responder
  import rv32i_types::*;
#(
  parameter int width      = 32,
  parameter int PMEM_WIDTH = 64,
  parameter int BEATS      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dmem_read_i,
  input  logic                  dmem_write_i,
  input  logic [width-1:0]      dmem_address_i,
  input  logic [width-1:0]      dmem_wdata_i,
  input  logic [3:0]            dmem_byte_en_i,
  output logic [width-1:0]      dmem_rdata_o,
  output logic                  dmem_resp_o,
  output logic                  pmem_read_o,
  output logic                  pmem_write_o,
  output logic [width-1:0]      pmem_address_o,
  output logic [PMEM_WIDTH-1:0] pmem_wdata_o,
  input  logic [PMEM_WIDTH-1:0] pmem_rdata_i,
  input  logic                  pmem_resp_i
);

  localparam int CW    = $clog2(BEATS);
  localparam int TAG_W = width - LINE_OFFSET_BITS;

  dmem_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [TAG_W-1:0]      req_tag, tag_q;
  logic [CW-1:0]         req_beat;
  logic                  req_half, req, hit, last;
  logic                  valid_q, dirty_q;
  logic                  fill_we, word_we;
  logic                  set_valid, clr_dirty, set_dirty;
  logic [PMEM_WIDTH-1:0] beat_rdata;
  logic [width-1:0]      word_rdata;
  logic                  addr_unused;

  assign req_tag     = dmem_address_i[width-1:LINE_OFFSET_BITS];
  assign req_beat    = dmem_address_i[BEAT_SEL_LSB +: CW];
  assign req_half    = dmem_address_i[BEAT_SEL_LSB-1];
  assign addr_unused = ^dmem_address_i[BEAT_SEL_LSB-2:0];
  assign req         = dmem_read_i | dmem_write_i;
  assign hit         = valid_q && (tag_q == req_tag);
  assign last        = cnt_q == CW'(BEATS-1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    fill_we        = 1'b0;
    word_we        = 1'b0;
    set_valid      = 1'b0;
    clr_dirty      = 1'b0;
    set_dirty      = 1'b0;
    dmem_rdata_o   = '0;
    dmem_resp_o    = 1'b0;
    pmem_read_o    = 1'b0;
    pmem_write_o   = 1'b0;
    pmem_address_o = '0;
    pmem_wdata_o   = '0;
    unique case (state_q)
      IDLE: begin
        if (req)
          state_d = hit ? RESP : (dirty_q ? WB : FILL);
      end
      WB: begin
        pmem_write_o   = 1'b1;
        pmem_address_o = {tag_q, {LINE_OFFSET_BITS{1'b0}}};
        pmem_wdata_o   = beat_rdata;
        if (pmem_resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            clr_dirty = 1'b1;
            cnt_d     = '0;
            state_d   = FILL;
          end
        end
      end
      FILL: begin
        pmem_read_o    = 1'b1;
        pmem_address_o = {req_tag, {LINE_OFFSET_BITS{1'b0}}};
        if (pmem_resp_i) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (last) begin
            set_valid = 1'b1;
            cnt_d     = '0;
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        dmem_resp_o = 1'b1;
        state_d     = IDLE;
        // Simultaneous read+write is serviced as a store.
        if (dmem_write_i) begin
          word_we   = 1'b1;
          set_dirty = 1'b1;
        end else begin
          dmem_rdata_o = word_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  dmem_line_store #(
    .width      (width),
    .PMEM_WIDTH (PMEM_WIDTH),
    .BEATS      (BEATS)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .fill_we    (fill_we),
    .fill_idx   (cnt_q),
    .fill_data  (pmem_rdata_i),
    .word_we    (word_we),
    .word_idx   (req_beat),
    .word_half  (req_half),
    .word_wdata (dmem_wdata_i),
    .word_be    (dmem_byte_en_i),
    .set_valid  (set_valid),
    .new_tag    (req_tag),
    .clr_dirty  (clr_dirty),
    .set_dirty  (set_dirty),
    .beat_idx   (cnt_q),
    .beat_rdata (beat_rdata),
    .word_rdata (word_rdata),
    .valid      (valid_q),
    .dirty      (dirty_q),
    .tag        (tag_q)
  );

endmodule
